// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, Q1.14 twiddle tables and sample packing for the 16-point FFT
//
// Purpose: constants and helpers common to the radix-4 butterfly stage and its lane multiplier.
// Ports: none (package).
package fft_pkg;

    localparam int DW    = 17;       // signed width of one real/imag component
    localparam int TW    = 16;       // signed twiddle width, Q1.14
    localparam int SW    = 2 * DW;   // packed sample width {imag, real}
    localparam int LANES = 4;
    localparam int NP    = 10;       // twiddle exponents p = n*k reach 0..9
    localparam int SATW  = 40;       // common width fed into the saturator

    // W16^p = cos(2*pi*p/16) - j*sin(2*pi*p/16), scaled by 2^14
    localparam logic signed [TW-1:0] COS_TAB [NP] = '{
        16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270,   16'sd0,
        -16'sd6270,  -16'sd11585, -16'sd15137, -16'sd16384, -16'sd15137
    };
    localparam logic signed [TW-1:0] SIN_TAB [NP] = '{
        16'sd0,      16'sd6270,   16'sd11585,  16'sd15137,  16'sd16384,
        16'sd15137,  16'sd11585,  16'sd6270,   16'sd0,      -16'sd6270
    };

    localparam logic signed [SATW-1:0] SAT_MAX = SATW'(2 ** (DW - 1) - 1);
    localparam logic signed [SATW-1:0] SAT_MIN = -SATW'(2 ** (DW - 1));

    function automatic logic [SW-1:0] pack_sample(input logic signed [DW-1:0] re,
                                                  input logic signed [DW-1:0] im);
        return {im, re};
    endfunction

    function automatic logic signed [DW-1:0] sample_re(input logic [SW-1:0] s);
        return s[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] sample_im(input logic [SW-1:0] s);
        return s[SW-1:DW];
    endfunction

    // Clamp a wide signed value into the DW-bit component range
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [SATW-1:0] v);
        logic signed [SATW-1:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[DW-1:0];
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// rtl/fft_cmul.sv - one-lane complex multiply by a Q1.14 twiddle with round and saturate
//
// Purpose: y = sat(round((x * w) / 2^14)), registered once.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset, clears y
//   x     packed sample {imag, real}, DW bits each
//   w_re  twiddle real part, Q1.14
//   w_im  twiddle imaginary part, Q1.14
//   y     packed product sample, valid one cycle after x
module fft_cmul
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SW-1:0]        x,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic [SW-1:0]        y
);

    localparam int PW   = DW + TW;     // full product width
    localparam int AW   = PW + 1;      // product sum width, no overflow possible
    localparam int FRAC = TW - 2;      // Q1.14 fractional bits
    localparam logic signed [AW-1:0] RND = AW'(2 ** (FRAC - 1));

    logic signed [DW-1:0] x_re;
    logic signed [DW-1:0] x_im;
    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] p_ir;
    logic signed [AW-1:0] acc_re;
    logic signed [AW-1:0] acc_im;
    logic signed [AW-1:0] sh_re;
    logic signed [AW-1:0] sh_im;

    assign x_re = sample_re(x);
    assign x_im = sample_im(x);

    assign p_rr = PW'(x_re) * PW'(w_re);
    assign p_ii = PW'(x_im) * PW'(w_im);
    assign p_ri = PW'(x_re) * PW'(w_im);
    assign p_ir = PW'(x_im) * PW'(w_re);

    // Round half up, then arithmetic shift; W=1 (16384) returns x exactly
    assign acc_re = AW'(p_rr) - AW'(p_ii) + RND;
    assign acc_im = AW'(p_ri) + AW'(p_ir) + RND;
    assign sh_re  = acc_re >>> FRAC;
    assign sh_im  = acc_im >>> FRAC;

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else begin
            y <= pack_sample(sat_dw(SATW'(sh_re)), sat_dw(SATW'(sh_im)));
        end
    end

endmodule

// File: rtl/fft16_r4_bfly_stage.sv
// rtl/fft16_r4_bfly_stage.sv - pipelined radix-4 butterfly stage of the 16-point FFT
//
// Purpose: per beat, twiddle four lanes by W16^(n*k), radix-4 butterfly, scale by 1/4.
//          Latency 3, one beat per cycle, no backpressure.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   data_in     4 lanes, lane n at [34n+33:34n] = {imag, real}
//   in_valid    data_in carries a beat this cycle
//   data_out    4 butterfly outputs X0..X3, same packing
//   out_valid   data_out valid; feeds the transpose buffer input enable
//   frame_done  pulses with out_valid of the k=3 beat of a frame
module fft16_r4_bfly_stage
    import fft_pkg::*;
#(
    parameter int TWIDDLE_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8*DW-1:0]   data_in,
    input  logic              in_valid,
    output logic [8*DW-1:0]   data_out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int BW  = DW + 2;   // butterfly sum width: four DW operands
    localparam int SCW = BW + 1;   // headroom for the rounding add

    logic [1:0]          k_cnt;
    logic [LANES*SW-1:0] s1_data;
    logic [1:0]          s1_k;
    logic                s1_valid;
    logic [LANES*SW-1:0] s2_data;
    logic [1:0]          s2_k;
    logic                s2_valid;

    // Beat counter advances only on accepted beats, so bubbles keep the frame phase
    always_ff @(posedge clk) begin
        if (rst) begin
            k_cnt <= '0;
        end else if (in_valid) begin
            k_cnt <= k_cnt + 2'd1;
        end
    end

    // S1: input capture; in_valid is masked by the reset branch
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_k     <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_data  <= data_in;
            s1_k     <= k_cnt;
            s1_valid <= in_valid;
        end
    end

    // S2: per-lane twiddle. Lane 0 always has p=0, so it is a plain register.
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [SW-1:0] lane_q;

        if (TWIDDLE_EN != 0 && n != 0) begin : g_cmul
            logic [3:0]           p_idx;
            logic signed [TW-1:0] w_re;
            logic signed [TW-1:0] w_im;

            assign p_idx = 4'(n) * {2'b00, s1_k};
            assign w_re  = COS_TAB[p_idx];
            assign w_im  = -SIN_TAB[p_idx];

            fft_cmul u_cmul (
                .clk  (clk),
                .rst  (rst),
                .x    (s1_data[n*SW +: SW]),
                .w_re (w_re),
                .w_im (w_im),
                .y    (lane_q)
            );
        end else begin : g_bypass
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_q <= '0;
                end else begin
                    lane_q <= s1_data[n*SW +: SW];
                end
            end
        end

        assign s2_data[n*SW +: SW] = lane_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_k     <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_k     <= s1_k;
            s2_valid <= s1_valid;
        end
    end

    // (v + 2) >>> 2 rounds the /4 scaling half up before clamping
    function automatic logic signed [DW-1:0] scale4(input logic signed [BW-1:0] v);
        logic signed [SCW-1:0] t;
        t = (SCW'(v) + SCW'(2)) >>> 2;
        return sat_dw(SATW'(t));
    endfunction

    // S3 combinational part: radix-4 butterfly, j*(r,i) = (-i,r)
    logic signed [BW-1:0] ln_re [LANES];
    logic signed [BW-1:0] ln_im [LANES];
    logic signed [BW-1:0] x_re  [LANES];
    logic signed [BW-1:0] x_im  [LANES];
    logic [LANES*SW-1:0]  bfly_out;

    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            ln_re[n] = BW'(sample_re(s2_data[n*SW +: SW]));
            ln_im[n] = BW'(sample_im(s2_data[n*SW +: SW]));
        end

        // X0 = a + b + c + d
        x_re[0] = ln_re[0] + ln_re[1] + ln_re[2] + ln_re[3];
        x_im[0] = ln_im[0] + ln_im[1] + ln_im[2] + ln_im[3];
        // X1 = a - jb - c + jd
        x_re[1] = ln_re[0] + ln_im[1] - ln_re[2] - ln_im[3];
        x_im[1] = ln_im[0] - ln_re[1] - ln_im[2] + ln_re[3];
        // X2 = a - b + c - d
        x_re[2] = ln_re[0] - ln_re[1] + ln_re[2] - ln_re[3];
        x_im[2] = ln_im[0] - ln_im[1] + ln_im[2] - ln_im[3];
        // X3 = a + jb - c - jd
        x_re[3] = ln_re[0] - ln_im[1] - ln_re[2] + ln_im[3];
        x_im[3] = ln_im[0] + ln_re[1] - ln_im[2] - ln_re[3];

        bfly_out = '0;
        for (int m = 0; m < LANES; m++) begin
            bfly_out[m*SW +: SW] = pack_sample(scale4(x_re[m]), scale4(x_im[m]));
        end
    end

    // S3 register: data holds across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= s2_valid;
            frame_done <= s2_valid && (s2_k == 2'd3);
            if (s2_valid) begin
                data_out <= bfly_out;
            end
        end
    end

endmodule

// File: tb/tb_fft16_r4_bfly_stage.sv
// tb/tb_fft16_r4_bfly_stage.sv - directed-vector bench for the radix-4 butterfly stage
module tb_fft16_r4_bfly_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [135:0] data_in = '0;
    logic         in_valid = 1'b0;
    logic [135:0] data_out;
    logic         out_valid;
    logic         frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int in_re [4];
        int in_im [4];
        int ex_re [4];
        int ex_im [4];
        int ex_fd;
    } vec_t;

    vec_t tbl [8];
    int   ex0 [8];

    fft16_r4_bfly_stage #(.TWIDDLE_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [135:0] pack4(input int re [4], input int im [4]);
        logic [135:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*34 +: 17]      = re[i][16:0];
            r[i*34 + 17 +: 17] = im[i][16:0];
        end
        return r;
    endfunction

    function automatic int out_re(input int m);
        logic signed [16:0] v;
        v = data_out[m*34 +: 17];
        return int'(v);
    endfunction

    function automatic int out_im(input int m);
        logic signed [16:0] v;
        v = data_out[m*34 + 17 +: 17];
        return int'(v);
    endfunction

    // Cycle-by-cycle sequence: mode 0 drives lane0=(4*beat,0), mode 1 drives lane1=(16384,0).
    // Bit c of eov/efd is the output expected in the sample taken after the edge ending cycle c.
    task automatic run_seq(input string name, input logic [15:0] vin, input logic [15:0] rin,
                           input logic [15:0] eov, input logic [15:0] efd,
                           input int ncyc, input int mode);
        int beat;
        int q;
        int re [4];
        int im [4];
        beat = 0;
        q    = 0;
        for (int c = 0; c < ncyc; c++) begin
            re = '{0, 0, 0, 0};
            im = '{0, 0, 0, 0};
            if (mode == 0) re[0] = 4 * beat;
            else           re[1] = 16384;
            data_in  = pack4(re, im);
            in_valid = vin[c];
            rst      = rin[c];
            if (vin[c] && !rin[c]) beat++;
            tick();
            check($sformatf("%s out_valid c%0d", name, c), int'(out_valid), int'(eov[c]));
            check($sformatf("%s frame_done c%0d", name, c), int'(frame_done), int'(efd[c]));
            if (eov[c]) begin
                check($sformatf("%s X0.re beat%0d", name, q), out_re(0), ex0[q]);
                q++;
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    initial begin
        // k=0 DC
        tbl[0].in_re = '{1000, 1000, 1000, 1000};
        tbl[0].ex_re = '{1000, 0, 0, 0};
        // k=1 lane1 unit: W16^1 = (15137,-6270)
        tbl[1].in_re = '{0, 16384, 0, 0};
        tbl[1].ex_re = '{3784, -1567, -3784, 1568};
        tbl[1].ex_im = '{-1567, -3784, 1568, 3784};
        // k=2 lane2 unit: W16^4 = (0,-16384)
        tbl[2].in_re = '{0, 0, 16384, 0};
        tbl[2].ex_im = '{-4096, 4096, -4096, 4096};
        // k=3 lane3 unit: W16^9 = (-15137,6270), closes frame
        tbl[3].in_re = '{0, 0, 0, 16384};
        tbl[3].ex_re = '{-3784, -1567, 3784, 1568};
        tbl[3].ex_im = '{1568, -3784, -1567, 3784};
        tbl[3].ex_fd = 1;
        // k=0 full-scale saturation corner
        tbl[4].in_re = '{65535, 65535, 65535, 65535};
        tbl[4].in_im = '{-65536, -65536, -65536, -65536};
        tbl[4].ex_re = '{65535, 0, 0, 0};
        tbl[4].ex_im = '{-65536, 0, 0, 0};
        // k=1 mixed signs: lane3 (-100,200)*W16^3 -> (147,169)
        tbl[5].in_re = '{400, 0, 0, -100};
        tbl[5].in_im = '{-800, 0, 0, 200};
        tbl[5].ex_re = '{137, 58, 63, 142};
        tbl[5].ex_im = '{-158, -163, -242, -237};
        // k=2 lane1 (1000,1000)*W16^2 -> (1414,0)
        tbl[6].in_re = '{0, 1000, 0, 0};
        tbl[6].in_im = '{0, 1000, 0, 0};
        tbl[6].ex_re = '{354, 0, -353, 0};
        tbl[6].ex_im = '{0, -353, 0, 354};
        // k=3 zero beat, closes frame
        tbl[7].ex_fd = 1;

        // Reset with in_valid asserted: must be ignored
        rst      = 1'b1;
        in_valid = 1'b1;
        data_in  = {136{1'b1}};
        for (int i = 0; i < 4; i++) tick();
        check("reset out_valid", int'(out_valid), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset data_out zero", int'(data_out != '0), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        tick();
        check("idle out_valid", int'(out_valid), 0);

        // Isolated beats, one every 3 cycles, checked at latency 3
        for (int i = 0; i < 8; i++) begin
            data_in  = pack4(tbl[i].in_re, tbl[i].in_im);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            data_in  = '0;
            tick();
            tick();
            check($sformatf("tbl%0d out_valid", i), int'(out_valid), 1);
            check($sformatf("tbl%0d frame_done", i), int'(frame_done), tbl[i].ex_fd);
            for (int m = 0; m < 4; m++) begin
                check($sformatf("tbl%0d X%0d.re", i, m), out_re(m), tbl[i].ex_re[m]);
                check($sformatf("tbl%0d X%0d.im", i, m), out_im(m), tbl[i].ex_im[m]);
            end
        end
        tick();
        check("post-table out_valid", int'(out_valid), 0);

        // 8 back-to-back beats: 8 consecutive outputs, frame_done on outputs 4 and 8
        ex0 = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_seq("stream", 16'h00FF, 16'h0000, 16'h03FC, 16'h0220, 12, 0);

        // Bubbles 1,0,1,0,1,1: k must step 0,1,2,3 across the gaps
        ex0 = '{4096, 3784, 2896, 1568, 0, 0, 0, 0};
        run_seq("bubble", 16'h0035, 16'h0000, 16'h00D4, 16'h0080, 10, 1);

        // Two beats, then rst for one cycle with in_valid high; then a full frame
        ex0 = '{4096, 3784, 2896, 1568, 0, 0, 0, 0};
        run_seq("rstmid", 16'h007F, 16'h0004, 16'h01E0, 16'h0100, 12, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
